// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types and line geometry constants.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;

    localparam int LC3B_LINE_OFFSET_BITS = 4;
    localparam int LC3B_WORDS_PER_LINE   = 8;

    // Pick one 16-bit word out of a 128-bit line; word 0 lives in bits [15:0].
    function automatic lc3b_word line_word(input lc3b_mem_data line, input logic [2:0] sel);
        return line[{sel, 4'h0} +: 16];
    endfunction

endpackage

// File: rtl/i_cache_nway_plru.sv
// Tree pseudo-LRU for one set: victim selection and tree update on access.
// Node n has children 2n+1 (left, lower ways) and 2n+2 (right); a node bit of
// 0 sends the victim search left, 1 sends it right.
module i_cache_plru #(
    parameter  int WAYS   = 2,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int TREE_W = WAYS - 1
) (
    input  logic [TREE_W-1:0] tree_i,
    input  logic [WAYS-1:0]   valid_i,
    input  logic [WAY_W-1:0]  way_i,
    input  logic              update_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [TREE_W-1:0] tree_o
);

    logic vic_found;
    logic vic_dir;
    int   vic_node;
    logic upd_bit;
    int   upd_node;

    // Victim: lowest-numbered invalid way, otherwise follow the tree from the root.
    always_comb begin
        victim_o  = '0;
        vic_found = 1'b0;
        vic_dir   = 1'b0;
        vic_node  = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !(1'(valid_i >> w))) begin
                victim_o  = WAY_W'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found) begin
            for (int l = 0; l < WAY_W; l++) begin
                vic_dir  = 1'(tree_i >> vic_node);
                victim_o = (victim_o << 1) | WAY_W'(vic_dir);
                vic_node = 2 * vic_node + 1 + int'(vic_dir);
            end
        end
    end

    // Update: every node on the accessed way's path is turned to point away from it.
    always_comb begin
        tree_o   = tree_i;
        upd_bit  = 1'b0;
        upd_node = 0;
        if (update_i) begin
            for (int l = 0; l < WAY_W; l++) begin
                upd_bit  = 1'(way_i >> (WAY_W - 1 - l));
                tree_o   = (tree_o & ~(TREE_W'(1) << upd_node)) | (TREE_W'(!upd_bit) << upd_node);
                upd_node = 2 * upd_node + 1 + int'(upd_bit);
            end
        end
    end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative read-only instruction cache for the LC-3b fetch path.
// Hits answer combinationally; misses fetch a 128-bit line over pmem_* and the
// request then hits on the cycle after the fill. flush invalidates every line.
module i_cache_nway
    import lc3b_types::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  lc3b_word     mem_address,
    input  logic         flush,
    output logic         mem_resp,
    output lc3b_word     mem_rdata,
    output logic         pmem_read,
    output lc3b_word     pmem_address,
    input  logic         pmem_resp,
    input  lc3b_mem_data pmem_rdata
);

    localparam int OFF_W  = LC3B_LINE_OFFSET_BITS;
    localparam int SEL_W  = $clog2(LC3B_WORDS_PER_LINE);
    localparam int LINE_W = 16 - OFF_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TREE_W = WAYS - 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    lc3b_mem_data      data_q  [SETS][WAYS];
    logic [TREE_W-1:0] plru_q  [SETS];

    logic [LINE_W-1:0] lk_line;
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [WAYS-1:0]   way_hit;
    logic              any_hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  acc_way;
    logic [TREE_W-1:0] tree_next;
    logic              idle_hit;
    logic              fill;
    logic              plru_upd;
    logic              unused_addr_bit;

    // While fetching, the latched miss line addresses the arrays so the fill
    // lands in the right set even if the fetch address wanders.
    assign lk_line = (state_q == S_FETCH) ? line_q : mem_address[15:OFF_W];
    assign lk_idx  = lk_line[IDX_W-1:0];
    assign lk_tag  = lk_line[LINE_W-1:IDX_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign way_hit[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
    end

    assign any_hit = |way_hit;

    // Encode the matching way (at most one way can match a given tag).
    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (1'(way_hit >> w)) hit_way = WAY_W'(w);
        end
    end

    assign idle_hit = (state_q == S_IDLE) && mem_read && any_hit;
    assign fill     = (state_q == S_FETCH) && pmem_resp;
    assign acc_way  = idle_hit ? hit_way : victim;
    assign plru_upd = idle_hit || fill;

    i_cache_plru #(
        .WAYS(WAYS)
    ) u_plru (
        .tree_i   (plru_q[lk_idx]),
        .valid_i  (valid_q[lk_idx]),
        .way_i    (acc_way),
        .update_i (plru_upd),
        .victim_o (victim),
        .tree_o   (tree_next)
    );

    assign mem_resp        = idle_hit;
    assign mem_rdata       = line_word(data_q[lk_idx][hit_way], mem_address[SEL_W:1]);
    assign pmem_read       = (state_q == S_FETCH);
    assign pmem_address    = {line_q, {OFF_W{1'b0}}};
    assign unused_addr_bit = mem_address[0];

    // Next state: a read miss in IDLE starts a line fetch; pmem_resp ends it.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read && !any_hit) begin
                    state_d = S_FETCH;
                    line_d  = mem_address[15:OFF_W];
                end
            end
            S_FETCH: begin
                if (pmem_resp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Miss line address, captured when the fetch starts.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // Valid bits: flush beats a coincident fill, so a flushed fill stays invalid.
    always_ff @(posedge clk) begin
        if (reset || flush) valid_q <= '{default: '0};
        else if (fill)      valid_q[lk_idx] <= valid_q[lk_idx] | (WAYS'(1) << victim);
    end

    // PLRU trees advance on every hit and every fill; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset)         plru_q <= '{default: '0};
        else if (plru_upd) plru_q[lk_idx] <= tree_next;
    end

    // Tag and line storage, written into the victim way on a fill.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[lk_idx][victim]  <= lk_tag;
            data_q[lk_idx][victim] <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_i_cache_nway.sv
// Bench for i_cache_nway (WAYS=4, SETS=8): directed vector table, hand-written
// flush/reset sequences and randomized reads against a behavioural cache model.
module tb_i_cache_nway;
    import lc3b_types::*;

    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic         clk;
    logic         reset;
    logic         mem_read;
    lc3b_word     mem_address;
    logic         flush;
    logic         mem_resp;
    lc3b_word     mem_rdata;
    logic         pmem_read;
    lc3b_word     pmem_address;
    logic         pmem_resp;
    lc3b_mem_data pmem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    i_cache_nway #(
        .WAYS(WAYS),
        .SETS(SETS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .flush        (flush),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory image ----------------
    function automatic lc3b_word img_word(input lc3b_word a);
        lc3b_word wa;
        wa = {a[15:1], 1'b0};
        if (wa == 16'h3006) return 16'hABCD;
        return wa ^ 16'h5AC3;
    endfunction

    function automatic lc3b_mem_data line_img(input lc3b_word la);
        lc3b_mem_data l;
        for (int i = 0; i < 8; i++) l[i*16 +: 16] = img_word(la + 16'(i * 2));
        return l;
    endfunction

    // ---------------- reference model ----------------
    // Each set remembers which line addresses it holds; replacement keeps, for
    // every way range [lo, lo+size), whether its left half was touched more
    // recently than its right half.
    bit       m_valid       [SETS][WAYS];
    lc3b_word m_line        [SETS][WAYS];
    bit       m_recent_left [SETS][WAYS][WAYS+1];

    function automatic int m_set(input lc3b_word a);
        return (int'(a) / 16) % SETS;
    endfunction

    function automatic int m_find(input lc3b_word a);
        int s;
        s = m_set(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == {a[15:4], 4'h0}) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        int lo, size;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0;
        size = WAYS;
        while (size > 1) begin
            if (m_recent_left[s][lo][size]) lo = lo + size / 2;
            size = size / 2;
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int way);
        int lo, size;
        lo = 0;
        size = WAYS;
        while (size > 1) begin
            if (way < lo + size / 2) begin
                m_recent_left[s][lo][size] = 1'b1;
            end else begin
                m_recent_left[s][lo][size] = 1'b0;
                lo = lo + size / 2;
            end
            size = size / 2;
        end
    endtask

    task automatic m_apply(input lc3b_word a);
        int s, w;
        s = m_set(a);
        w = m_find(a);
        if (w < 0) begin
            w = m_victim(s);
            m_valid[s][w] = 1'b1;
            m_line[s][w]  = {a[15:4], 4'h0};
        end
        m_touch(s, w);
    endtask

    task automatic m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        for (int s = 0; s < SETS; s++)
            for (int lo = 0; lo < WAYS; lo++)
                for (int z = 0; z <= WAYS; z++) m_recent_left[s][lo][z] = 1'b0;
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One fetch transaction. Entered and left at posedge+1. With flush_on_resp
    // the fill is answered together with a flush and the task returns right
    // after that edge with mem_read still high.
    task automatic read_txn(input string nm, input lc3b_word a, input bit exp_hit,
                            input lc3b_word exp_w, input int lat, input bit flush_on_resp);
        lc3b_word la;
        la = {a[15:4], 4'h0};
        mem_read    = 1'b1;
        mem_address = a;
        #1;
        check({nm, " resp"}, 32'(mem_resp), 32'(exp_hit));
        if (exp_hit) begin
            check({nm, " data"}, 32'(mem_rdata), 32'(exp_w));
            check({nm, " no pmem_read"}, 32'(pmem_read), 32'd0);
            tick();
            mem_read = 1'b0;
            return;
        end
        tick();
        check({nm, " pmem_read"}, 32'(pmem_read), 32'd1);
        check({nm, " pmem_address"}, 32'(pmem_address), 32'(la));
        for (int i = 0; i < lat; i++) begin
            tick();
            check({nm, " pmem_address hold"}, 32'(pmem_address), 32'(la));
        end
        pmem_resp  = 1'b1;
        pmem_rdata = line_img(la);
        flush      = flush_on_resp;
        tick();
        pmem_resp = 1'b0;
        flush     = 1'b0;
        if (flush_on_resp) return;
        #1;
        check({nm, " fill resp"}, 32'(mem_resp), 32'd1);
        check({nm, " fill data"}, 32'(mem_rdata), 32'(exp_w));
        check({nm, " pmem_read low"}, 32'(pmem_read), 32'd0);
        tick();
        mem_read = 1'b0;
    endtask

    task automatic model_read(input string nm, input lc3b_word a, input int lat);
        bit h;
        h = (m_find(a) >= 0);
        read_txn(nm, a, h, img_word(a), lat, 1'b0);
        m_apply(a);
    endtask

    typedef struct {
        lc3b_word addr;
        bit       exp_hit;
        lc3b_word exp_rdata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h3006, 1'b0, 16'hABCD};
        tbl[1]  = '{16'h3006, 1'b1, 16'hABCD};
        tbl[2]  = '{16'h3080, 1'b0, img_word(16'h3080)};
        tbl[3]  = '{16'h3100, 1'b0, img_word(16'h3100)};
        tbl[4]  = '{16'h3180, 1'b0, img_word(16'h3180)};
        tbl[5]  = '{16'h3000, 1'b1, img_word(16'h3000)};
        tbl[6]  = '{16'h3200, 1'b0, img_word(16'h3200)};
        tbl[7]  = '{16'h3080, 1'b1, img_word(16'h3080)};
        tbl[8]  = '{16'h3100, 1'b0, img_word(16'h3100)};
        tbl[9]  = '{16'h3200, 1'b1, img_word(16'h3200)};
        tbl[10] = '{16'h3180, 1'b0, img_word(16'h3180)};

        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        flush       = 1'b0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset pmem_read", 32'(pmem_read), 32'd0);
        check("reset mem_resp", 32'(mem_resp), 32'd0);
        tick();

        // Cold miss, hit, and PLRU replacement in set 0.
        for (int i = 0; i < 11; i++) begin
            read_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_rdata, 1, 1'b0);
            m_apply(tbl[i].addr);
        end

        // Flush pulse on its own, then a flush coincident with a hit.
        model_read("t4 load", 16'h3000, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_flush();
        read_txn("t4 after flush", 16'h3000, 1'b0, img_word(16'h3000), 0, 1'b0);
        m_apply(16'h3000);
        mem_read    = 1'b1;
        mem_address = 16'h3004;
        flush       = 1'b1;
        #1;
        check("t4 hit+flush resp", 32'(mem_resp), 32'd1);
        check("t4 hit+flush data", 32'(mem_rdata), 32'(img_word(16'h3004)));
        tick();
        flush    = 1'b0;
        mem_read = 1'b0;
        m_apply(16'h3004);
        m_flush();
        read_txn("t4 reread", 16'h3004, 1'b0, img_word(16'h3004), 1, 1'b0);
        m_apply(16'h3004);

        // Flush in the same cycle as pmem_resp on a fill of x4000.
        read_txn("t5 fill", 16'h4000, 1'b0, img_word(16'h4000), 1, 1'b1);
        m_apply(16'h4000);
        m_flush();
        #1;
        check("t5 no resp", 32'(mem_resp), 32'd0);
        check("t5 idle pmem_read", 32'(pmem_read), 32'd0);
        tick();
        check("t5 refetch pmem_read", 32'(pmem_read), 32'd1);
        check("t5 refetch address", 32'(pmem_address), 32'h4000);
        pmem_resp  = 1'b1;
        pmem_rdata = line_img(16'h4000);
        tick();
        pmem_resp = 1'b0;
        #1;
        check("t5 resp", 32'(mem_resp), 32'd1);
        check("t5 data", 32'(mem_rdata), 32'(img_word(16'h4000)));
        m_apply(16'h4000);
        tick();
        mem_read = 1'b0;

        // Randomized reads over a few conflicting lines in two sets.
        for (int i = 0; i < 150; i++) begin
            int t, s, wd;
            lc3b_word a;
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                m_flush();
            end
            t  = $urandom_range(0, 5);
            s  = $urandom_range(0, 1);
            wd = $urandom_range(0, 7);
            a  = 16'(32'h6000 + t * 128 + s * 16 + wd * 2 + $urandom_range(0, 1));
            model_read($sformatf("rnd%0d", i), a, $urandom_range(0, 3));
        end

        // Reset while a fetch is outstanding; the late pmem_resp is ignored.
        mem_read    = 1'b1;
        mem_address = 16'h7770;
        #1;
        check("t6 miss resp", 32'(mem_resp), 32'd0);
        tick();
        check("t6 pmem_read", 32'(pmem_read), 32'd1);
        reset    = 1'b1;
        mem_read = 1'b0;
        tick();
        reset = 1'b0;
        m_reset();
        check("t6 pmem_read after reset", 32'(pmem_read), 32'd0);
        pmem_resp  = 1'b1;
        pmem_rdata = line_img(16'h7770);
        #1;
        check("t6 late resp ignored", 32'(mem_resp), 32'd0);
        tick();
        pmem_resp = 1'b0;
        check("t6 still idle", 32'(pmem_read), 32'd0);
        read_txn("t6 reread", 16'h7770, 1'b0, img_word(16'h7770), 1, 1'b0);
        m_apply(16'h7770);
        model_read("t6 x3006", 16'h3006, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
